divide_seq: RTL and testbench

- Multi-cycle, parametrised restoring divider for the CPU datapath's DIV/DIVU instructions.
- Produces quotient and remainder, so the HI/LO registers can load {remainder, quotient} directly.
- Computes one quotient bit per clock, replacing the single-cycle combinational divide that limits Fmax.
- Uses a start/busy/done handshake so the control unit stalls until the result is valid.

---
 rtl/divide_seq.sv | 147 ++++++++++++++
 tb/tb_divide_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/divide_seq.sv
// rtl/divide_seq.sv - multi-cycle restoring divider, one quotient bit per clock
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   clr        synchronous active-low reset
//   start      divide request, accepted only while busy is low
//   dividend   numerator, captured on an accepted start
//   divisor    denominator, captured on an accepted start
//   is_signed  (DIVIDE_SEQ_SIGNED_EN only) treat operands as two's complement
//   busy       high from acceptance until the done pulse has passed
//   done       one-cycle pulse when quotient/remainder become valid
//   quotient   result quotient, held until the next accepted start
//   remainder  result remainder, held until the next accepted start
//   div_zero   latest result came from a zero divisor
//
// Optional feature macro: DIVIDE_SEQ_SIGNED_EN (signed division, truncating toward zero).

module divide_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDE_SEQ_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state;
    // Partial remainder. Every iteration leaves it strictly below M, so the
    // extra sign bit is only needed in the working value, not in storage.
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic             zero_op;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   a_sub;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             accept;

    // {A,Q} shifted left, then trial subtraction; a set sign bit means restore.
    assign a_sh  = {a, q[WIDTH-1]};
    assign a_sub = a_sh - {1'b0, m};

    // The done cycle still counts as busy so a start there is not taken.
    assign busy   = (state != S_IDLE) || done;
    assign accept = start && !busy;

`ifdef DIVIDE_SEQ_SIGNED_EN
    logic q_neg;
    logic r_neg;
    logic [WIDTH-1:0] mag_r;

    assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? '0 - dividend : dividend;
    assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? '0 - divisor  : divisor;
    // On divide-by-zero Q still holds the dividend magnitude; re-applying the
    // dividend sign gives back the original dividend as the remainder.
    assign mag_r = zero_op ? q : a;
    assign res_r = r_neg ? '0 - mag_r : mag_r;
    assign res_q = zero_op ? '1 : (q_neg ? '0 - q : q);
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign res_r   = zero_op ? q : a;
    assign res_q   = zero_op ? '1 : q;
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= S_IDLE;
            a         <= '0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
            zero_op   <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef DIVIDE_SEQ_SIGNED_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a       <= '0;
                        q       <= dvd_mag;
                        m       <= dvs_mag;
                        zero_op <= (divisor == '0);
`ifdef DIVIDE_SEQ_SIGNED_EN
                        q_neg   <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg   <= is_signed && dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            state <= S_FINISH;
                        end else begin
                            cnt   <= CNT_W'(WIDTH);
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (a_sub[WIDTH]) begin
                        a <= a_sh[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b0};
                    end else begin
                        a <= a_sub[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    quotient  <= res_q;
                    remainder <= res_r;
                    div_zero  <= zero_op;
                    done      <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_seq.sv
// tb/tb_divide_seq.sv - self-checking bench for divide_seq (WIDTH=32 and WIDTH=8 instances)

module tb_divide_seq;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    logic        start32, start8;
    logic [31:0] dvd32, dvs32;
    logic [7:0]  dvd8, dvs8;
    logic        sgn32, sgn8;
    wire         busy32, done32, dz32, busy8, done8, dz8;
    wire  [31:0] q32, r32;
    wire  [7:0]  q8, r8;

    divide_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .clr(clr), .start(start32), .dividend(dvd32), .divisor(dvs32),
`ifdef DIVIDE_SEQ_SIGNED_EN
        .is_signed(sgn32),
`endif
        .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .div_zero(dz32)
    );

    divide_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .dividend(dvd8), .divisor(dvs8),
`ifdef DIVIDE_SEQ_SIGNED_EN
        .is_signed(sgn8),
`endif
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_zero(dz8)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input bit s, input bit w8);
        exp_t        e;
        logic [31:0] mask;
        longint      sa, sb_v;
        mask = w8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
        if (b == 0) begin
            e.q = mask; e.r = a; e.z = 1'b1;
        end else if (s) begin
            sa   = w8 ? longint'($signed(a[7:0])) : longint'($signed(a));
            sb_v = w8 ? longint'($signed(b[7:0])) : longint'($signed(b));
            e.q = 32'(sa / sb_v) & mask;
            e.r = 32'(sa % sb_v) & mask;
            e.z = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.z = 1'b0;
        end
        return e;
    endfunction

    // Drive a request (sampled at the next edge) and push its expected result.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit s, input bit w8);
        if (w8) begin
            dvd8 = a[7:0]; dvs8 = b[7:0]; sgn8 = s; start8 = 1'b1;
        end else begin
            dvd32 = a; dvs32 = b; sgn32 = s; start32 = 1'b1;
        end
        sb.push_back(model(a, b, s, w8));
    endtask

    // Acceptance edge: drop start and confirm busy rose.
    task automatic accept(input string tag, input bit w8);
        @(posedge clk); #1;
        start32 = 1'b0; start8 = 1'b0;
        check({tag, "_busy"}, w8 ? busy8 : busy32, 1'b1);
    endtask

    // Count edges until done, then compare with the oldest scoreboard entry.
    task automatic wait_done(input string tag, input int lat, input bit w8);
        int   n;
        exp_t e;
        n = 0;
        while ((w8 ? done8 : done32) !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, lat);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            check({tag, "_quot"}, w8 ? {24'h0, q8} : q32, e.q);
            check({tag, "_rem"},  w8 ? {24'h0, r8} : r32, e.r);
            check({tag, "_dz"},   w8 ? dz8 : dz32, e.z);
        end
    endtask

    task automatic pulse_end(input string tag, input bit w8);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, w8 ? done8 : done32, 1'b0);
        check({tag, "_busy_low"},  w8 ? busy8 : busy32, 1'b0);
    endtask

    initial begin
        bit seen;
        clr = 1'b0; start32 = 1'b0; start8 = 1'b0;
        dvd32 = '0; dvs32 = '0; dvd8 = '0; dvs8 = '0; sgn32 = 1'b0; sgn8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy32, 1'b0);
        check("rst_done", done32, 1'b0);
        check("rst_q",    q32, 32'h0);
        check("rst_r",    r32, 32'h0);
        check("rst_dz",   dz32, 1'b0);
        check("rst_q8",   q8, 8'h0);
        clr = 1'b1;
        @(posedge clk); #1;

        // 100/7, full latency and pulse shape
        launch(32'd100, 32'd7, 1'b0, 1'b0);
        accept("d100_7", 1'b0);
        wait_done("d100_7", 33, 1'b0);
        pulse_end("d100_7", 1'b0);

        // divide by zero
        launch(32'd5, 32'd0, 1'b0, 1'b0);
        accept("dz5", 1'b0);
        wait_done("dz5", 1, 1'b0);
        pulse_end("dz5", 1'b0);

        // second start while busy is ignored
        launch(32'd100, 32'd7, 1'b0, 1'b0);
        accept("ign", 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        dvd32 = 32'd9; dvs32 = 32'd3; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        wait_done("ign", 29, 1'b0);
        // start raised during the done cycle is not taken until the next cycle
        launch(32'd9, 32'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("done_cyc_start_busy", busy32, 1'b0);
        accept("d9_3", 1'b0);
        wait_done("d9_3", 33, 1'b0);
        pulse_end("d9_3", 1'b0);

        // reset mid-divide aborts without a done pulse
        dvd32 = 32'hFFFF_FFFF; dvs32 = 32'd1; start32 = 1'b1;
        accept("abort", 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        clr = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        check("abort_busy", busy32, 1'b0);
        check("abort_done", done32, 1'b0);
        check("abort_q",    q32, 32'h0);
        check("abort_r",    r32, 32'h0);
        check("abort_dz",   dz32, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32) seen = 1'b1;
        end
        check("abort_no_done", seen, 1'b0);
        launch(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
        accept("post_rst", 1'b0);
        wait_done("post_rst", 33, 1'b0);
        pulse_end("post_rst", 1'b0);

        // a few random unsigned divides
        for (int i = 0; i < 4; i++) begin
            launch($urandom, $urandom_range(1, 5000), 1'b0, 1'b0);
            accept("rnd", 1'b0);
            wait_done("rnd", 33, 1'b0);
            pulse_end("rnd", 1'b0);
        end

        // WIDTH=8 instance
        launch(32'd255, 32'd16, 1'b0, 1'b1);
        accept("w8_255_16", 1'b1);
        wait_done("w8_255_16", 9, 1'b1);
        pulse_end("w8_255_16", 1'b1);
        launch(32'd3, 32'd200, 1'b0, 1'b1);
        accept("w8_3_200", 1'b1);
        wait_done("w8_3_200", 9, 1'b1);
        pulse_end("w8_3_200", 1'b1);
        launch(32'd255, 32'd1, 1'b0, 1'b1);
        accept("w8_255_1", 1'b1);
        wait_done("w8_255_1", 9, 1'b1);
        pulse_end("w8_255_1", 1'b1);

`ifdef DIVIDE_SEQ_SIGNED_EN
        launch(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
        accept("s_m100_7", 1'b0);
        wait_done("s_m100_7", 33, 1'b0);
        pulse_end("s_m100_7", 1'b0);
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        accept("s_minneg", 1'b0);
        wait_done("s_minneg", 33, 1'b0);
        pulse_end("s_minneg", 1'b0);
        launch(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);
        accept("u_m100_7", 1'b0);
        wait_done("u_m100_7", 33, 1'b0);
        pulse_end("u_m100_7", 1'b0);
        launch(32'hFFFF_FF9C, 32'd0, 1'b1, 1'b0);
        accept("s_dz", 1'b0);
        wait_done("s_dz", 1, 1'b0);
        pulse_end("s_dz", 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
